// File: rtl/pwm_fade_ctrl_if.sv
// Control/config and status bundle for the PWM fade sequencer.
// master = config/software side, slave = sequencer.
interface pwm_fade_ctrl_if #(
  parameter int W  = 8,
  parameter int HW = 16
);
  logic          i_start;
  logic          i_stop;
  logic [W-1:0]  i_cfg_min;
  logic [W-1:0]  i_cfg_max;
  logic [W-1:0]  i_cfg_step;
  logic [HW-1:0] i_cfg_hold;
  logic [7:0]    i_cfg_repeat;
  logic          o_led;
  logic [W-1:0]  o_duty;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  modport master (
    output i_start, i_stop, i_cfg_min, i_cfg_max, i_cfg_step, i_cfg_hold, i_cfg_repeat,
    input  o_led, o_duty, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_stop, i_cfg_min, i_cfg_max, i_cfg_step, i_cfg_hold, i_cfg_repeat,
    output o_led, o_duty, o_busy, o_done, o_err
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Breathing-profile sequencer for one PWM LED channel: free-running counter,
// period-aligned duty updates, ramp up / hold / ramp down / hold, repeat.
module pwm_fade_ctrl #(
  parameter int W  = 8,
  parameter int HW = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  pwm_fade_ctrl_if.slave io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO
  } state_t;

  state_t        r_state, w_state_nx;
  logic [W-1:0]  r_cnt;
  logic [W-1:0]  r_duty, w_duty_nx;
  logic [W-1:0]  r_min, r_max, r_step;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] r_hc, w_hc_nx;
  logic [7:0]    r_rem, w_rem_nx;
  logic          r_led;
  logic          r_done, w_done_nx;
  logic          r_err, w_err_nx;
  logic          r_stop_pend, w_stop_nx;
  logic          w_cap, w_breath;
  logic          w_tick, w_stop_any, w_last;
  logic [W:0]    w_add, w_sub;
  logic [W-1:0]  w_up, w_dn;

  assign w_tick     = (r_cnt == '1);
  assign w_add      = {1'b0, r_duty} + {1'b0, r_step};
  assign w_sub      = {1'b0, r_duty} - {1'b0, r_step};
  // Borrow out of the W+1-bit subtract means the ramp undershot zero.
  assign w_up       = (w_add >= {1'b0, r_max}) ? r_max : w_add[W-1:0];
  assign w_dn       = (w_sub[W] || (w_sub[W-1:0] <= r_min)) ? r_min : w_sub[W-1:0];
  assign w_stop_any = r_stop_pend | io_bus.i_stop;
  assign w_last     = (r_rem == 8'd1) || w_stop_any;

  always_comb begin
    w_state_nx = r_state;
    w_duty_nx  = r_duty;
    w_hc_nx    = r_hc;
    w_rem_nx   = r_rem;
    w_stop_nx  = (r_state != S_IDLE) && w_stop_any;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    w_cap      = 1'b0;
    w_breath   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (io_bus.i_start && !io_bus.i_stop) begin
          if (io_bus.i_cfg_min > io_bus.i_cfg_max) begin
            w_err_nx = 1'b1;
          end else begin
            w_cap      = 1'b1;
            w_rem_nx   = io_bus.i_cfg_repeat;
            w_state_nx = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_tick) begin
          if (w_stop_any) begin
            w_state_nx = S_DOWN;
          end else begin
            w_duty_nx  = r_min;
            w_state_nx = S_UP;
          end
        end
      end
      S_UP: begin
        if (w_tick) begin
          if (w_stop_any) begin
            w_state_nx = S_DOWN;
          end else begin
            w_duty_nx = w_up;
            if (w_up == r_max) begin
              w_hc_nx    = r_hold;
              w_state_nx = (r_hold == '0) ? S_DOWN : S_HOLD_HI;
            end
          end
        end
      end
      S_HOLD_HI: begin
        if (w_tick) begin
          if (w_stop_any || (r_hc == HW'(1))) begin
            w_state_nx = S_DOWN;
          end else begin
            w_hc_nx = r_hc - HW'(1);
          end
        end
      end
      S_DOWN: begin
        if (w_tick) begin
          w_duty_nx = w_dn;
          if (w_dn == r_min) begin
            if (r_hold == '0) begin
              w_breath = 1'b1;
            end else begin
              w_hc_nx    = r_hold;
              w_state_nx = S_HOLD_LO;
            end
          end
        end
      end
      S_HOLD_LO: begin
        if (w_tick) begin
          if (r_hc == HW'(1)) begin
            w_breath = 1'b1;
          end else begin
            w_hc_nx = r_hc - HW'(1);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    // End of a breath is shared by DOWN (zero hold) and HOLD_LO.
    if (w_breath) begin
      if (w_last) begin
        w_state_nx = S_IDLE;
        w_duty_nx  = '0;
        w_done_nx  = 1'b1;
        w_stop_nx  = 1'b0;
      end else begin
        w_state_nx = S_UP;
        if (r_rem != 8'd0) begin
          w_rem_nx = r_rem - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_duty      <= '0;
      r_hc        <= '0;
      r_rem       <= '0;
      r_stop_pend <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_min       <= '0;
      r_max       <= '0;
      r_step      <= '0;
      r_hold      <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_duty      <= w_duty_nx;
      r_hc        <= w_hc_nx;
      r_rem       <= w_rem_nx;
      r_stop_pend <= w_stop_nx;
      r_done      <= w_done_nx;
      r_err       <= w_err_nx;
      if (w_cap) begin
        r_min  <= io_bus.i_cfg_min;
        r_max  <= io_bus.i_cfg_max;
        r_step <= (io_bus.i_cfg_step == '0) ? W'(1) : io_bus.i_cfg_step;
        r_hold <= io_bus.i_cfg_hold;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_led <= (r_cnt < r_duty);
    end
  end

  assign io_bus.o_led  = r_led;
  assign io_bus.o_duty = r_duty;
  assign io_bus.o_busy = (r_state != S_IDLE);
  assign io_bus.o_done = r_done;
  assign io_bus.o_err  = r_err;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: table of breathing profiles with
// expected per-period duty/led-high counts, plus stop/cfg/reset sequences.
module tb_pwm_fade_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_fade_ctrl_if #(.W(8), .HW(16)) bus ();

  pwm_fade_ctrl #(.W(8), .HW(16)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  // Bench-side reference of the period phase.
  logic [7:0] tcnt;
  always @(posedge clk) tcnt <= rst ? 8'd0 : tcnt + 8'd1;

  int errors = 0;
  int checks = 0;
  bit prev_busy = 1'b0;

  typedef struct {
    int mn;
    int mx;
    int st;
    int hold;
    int rep;
    int n;
    bit err;
    int row;
  } vec_t;

  vec_t tbl[6];
  int exp_tab[6][16] = '{
    '{0, 4, 8, 8, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 100, 200, 250, 150, 50, 0, 100, 200, 250, 150, 50, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{5, 5, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{253, 254, 255, 254, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
    '{3, 7, 10, 10, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input vec_t v);
    bus.i_cfg_min    = 8'(v.mn);
    bus.i_cfg_max    = 8'(v.mx);
    bus.i_cfg_step   = 8'(v.st);
    bus.i_cfg_hold   = 16'(v.hold);
    bus.i_cfg_repeat = 8'(v.rep);
  endtask

  // One full PWM period, samples at negedge for tcnt = 1..255,0.
  // act: 1 = stop pulse mid-period, 2 = cfg change + start pulse mid-period.
  task automatic measure(input int act, output int hi, output int d,
                         output int nd, output int nb, output int ab);
    hi = 0; d = 0; nd = 0; nb = 0; ab = 0;
    @(negedge clk);
    while (tcnt != 8'd1) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) d = int'(bus.o_duty);
      if (i == 100) begin
        if (act == 1) begin
          bus.i_stop = 1'b1;
        end else if (act == 2) begin
          bus.i_cfg_max = 8'd200;
          bus.i_start   = 1'b1;
        end
      end
      if (i == 101) begin
        bus.i_stop  = 1'b0;
        bus.i_start = 1'b0;
      end
      hi += int'(bus.o_led);
      if (bus.o_done) begin
        nd++;
        if (bus.o_busy || !prev_busy) ab++;
      end
      if (bus.o_busy) nb++;
      prev_busy = bus.o_busy;
    end
  endtask

  task automatic run_seq(input vec_t v, input string tag, input int act_win,
                         input int act, input bit no_rst);
    int hi, d, nd, nb, ab, ndone, dwin, abad, bad;
    if (!no_rst) do_reset();
    set_cfg(v);
    while (tcnt != 8'd10) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    if (v.err) begin
      check({tag, "_err_pulse"}, int'(bus.o_err), 1);
      check({tag, "_err_busy"}, int'(bus.o_busy), 0);
      @(negedge clk);
      check({tag, "_err_clear"}, int'(bus.o_err), 0);
      bad = 0;
      repeat (300) begin
        @(negedge clk);
        if (bus.o_busy || bus.o_led || bus.o_err) bad++;
      end
      check({tag, "_err_idle"}, bad, 0);
      return;
    end
    check({tag, "_busy_start"}, int'(bus.o_busy), 1);
    check({tag, "_no_err"}, int'(bus.o_err), 0);
    ndone = 0; dwin = -1; abad = 0;
    for (int w = 0; w < v.n; w++) begin
      measure((w == act_win) ? act : 0, hi, d, nd, nb, ab);
      check($sformatf("%s_w%0d_hi", tag, w), hi, exp_tab[v.row][w]);
      check($sformatf("%s_w%0d_duty", tag, w), d, exp_tab[v.row][w]);
      if (nd > 0) begin
        ndone += nd;
        dwin = w;
      end
      abad += ab;
    end
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_done_period"}, dwin, v.n - 2);
    check({tag, "_done_busy_align"}, abad, 0);
    measure(0, hi, d, nd, nb, ab);
    check({tag, "_idle_hi"}, hi, 0);
    check({tag, "_idle_done"}, nd, 0);
    check({tag, "_idle_busy"}, nb, 0);
    check({tag, "_idle_duty"}, d, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bus.i_start      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_cfg_min    = 8'd0;
    bus.i_cfg_max    = 8'd0;
    bus.i_cfg_step   = 8'd0;
    bus.i_cfg_hold   = 16'd0;
    bus.i_cfg_repeat = 8'd0;

    //           mn   mx   st  hold rep  n  err row
    tbl[0] = '{  0,   8,   4,  1,   1,   7, 1'b0, 0};
    tbl[1] = '{  0, 250, 100,  0,   2,  13, 1'b0, 1};
    tbl[2] = '{ 10,   5,   1,  1,   1,   0, 1'b1, 2};
    tbl[3] = '{  5,   5,   3,  2,   1,   7, 1'b0, 3};
    tbl[4] = '{253, 255,   0,  0,   1,   5, 1'b0, 4};
    tbl[5] = '{  3,  10,   4,  1,   1,   7, 1'b0, 5};

    do_reset();
    @(negedge clk);
    check("rst_led",  int'(bus.o_led),  0);
    check("rst_duty", int'(bus.o_duty), 0);
    check("rst_busy", int'(bus.o_busy), 0);
    check("rst_done", int'(bus.o_done), 0);
    check("rst_err",  int'(bus.o_err),  0);

    for (int i = 0; i < 6; i++) begin
      run_seq(tbl[i], $sformatf("v%0d", i), -1, 0, 1'b0);
    end

    // Graceful stop during the second duty-8 period of an infinite run.
    v = tbl[0];
    v.rep = 0;
    run_seq(v, "stop", 3, 1, 1'b0);

    // Config edits and start pulses while busy must not disturb the run.
    run_seq(tbl[0], "cfgchg", 1, 2, 1'b0);

    // Start and stop together in IDLE: stop wins, no err; stop alone ignored.
    do_reset();
    set_cfg(tbl[0]);
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    check("startstop_busy", int'(bus.o_busy), 0);
    check("startstop_err",  int'(bus.o_err),  0);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    @(negedge clk);
    check("idle_stop_busy", int'(bus.o_busy), 0);

    // Reset asserted mid HOLD_HI, then a fresh start without extra reset.
    do_reset();
    set_cfg(tbl[0]);
    while (tcnt != 8'd10) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      int hi, d, nd, nb, ab;
      measure(0, hi, d, nd, nb, ab);
      check($sformatf("rstmid_w%0d_hi", w), hi, exp_tab[0][w]);
    end
    while (tcnt != 8'd2) @(negedge clk);
    check("rstmid_pre_led",  int'(bus.o_led),  1);
    check("rstmid_pre_duty", int'(bus.o_duty), 8);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_led",  int'(bus.o_led),  0);
    check("rstmid_duty", int'(bus.o_duty), 0);
    check("rstmid_busy", int'(bus.o_busy), 0);
    check("rstmid_done", int'(bus.o_done), 0);
    rst = 1'b0;
    run_seq(tbl[0], "afterrst", -1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer for an 8-bit PWM LED channel. Owns a free-running PWM counter and a glitch-free duty register, and steps the duty through a configurable breathing profile: ramp up, hold high, ramp down, hold low, repeat.
- Sits between the software/config side (start/stop pulses, profile registers) and the LED pin.
- Replaces free-running duty drift with a controlled, repeatable fade sequence.

Parameters:
- W, 8, PWM counter and duty width; PWM period = 2^W clk cycles.
- HW, 16, width of hold-period count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin a sequence (accepted only in IDLE)
- stop  in  1  one-cycle pulse; graceful fade-out request
- cfg_min  in  W  low duty level
- cfg_max  in  W  high duty level
- cfg_step  in  W  duty increment/decrement per PWM period
- cfg_hold  in  HW  extra periods held at max and at min
- cfg_repeat  in  8  number of breaths; 0 = infinite
- led  out  1  PWM output
- duty  out  W  currently applied duty
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence ends
- err  out  1  one-cycle pulse when start is rejected because cfg_min > cfg_max

Behaviour:
- Reset values: cnt=0, duty=0, led=0, busy=0, done=0, err=0, state=IDLE, stop_pend=0.
- PWM counter cnt: free-running, increments every cycle, wraps 2^W-1 -> 0, runs in all states.
- tick = (cnt == 2^W-1). All duty and state updates occur only on tick edges, so duty is constant over each full period.
- led is registered: led <= (cnt < duty). This gives 1 cycle of latency and exactly `duty` high cycles per period. duty=0 gives always low; max duty (255) gives 255 of 256 cycles high.
- Config is captured into shadow registers on start acceptance. Later cfg changes have no effect until the next start.
- cfg_step=0 is treated as 1.
- Add and subtract are computed in W+1 bits and saturate at shadow max and min respectively.
- FSM states: IDLE, LOAD, UP, HOLD_HI, DOWN, HOLD_LO. Transitions below happen on tick unless stated otherwise.
  - IDLE: start with cfg_min <= cfg_max -> LOAD, busy=1 on the next cycle. Capture config; rem = cfg_repeat. start with cfg_min > cfg_max -> err pulse, stay IDLE.
  - LOAD: duty <= min -> UP.
  - UP: duty <= sat(duty+step). If the new duty == max -> HOLD_HI with hc=hold, or straight to DOWN if hold==0.
  - HOLD_HI: duty unchanged. If hc==1 -> DOWN, else hc--.
  - DOWN: duty <= sat(duty-step). If the new duty == min -> HOLD_LO with hc=hold. If hold==0, the breath-complete rule applies immediately.
  - HOLD_LO: duty unchanged. If hc==1 -> breath complete, else hc--.
  - Breath complete: if rem==1 or stop_pend -> IDLE, duty <= 0, busy=0, done pulse (same edge). Otherwise -> UP, decrementing rem if rem != 0; rem==0 means infinite.
- min==max: UP saturates at once and the profile degenerates to holds; it must still terminate per rem.
- stop:
  - Sets stop_pend in any non-IDLE state; the flag is held until the sequence ends.
  - In LOAD, UP or HOLD_HI: the next tick forces DOWN, with duty stepping down from its current value.
  - In DOWN or HOLD_LO: the current ramp/hold completes, then the sequence ends.
  - stop in IDLE is ignored.
- Simultaneous start and stop in IDLE: stop wins, start is ignored and no err is raised.
- start while busy: ignored.
- rst mid-operation: all registers return to reset values on the next edge; led is low from that edge.

Test Plan:
- W=8, min=0, max=8, step=4, hold=1, repeat=1; start once -> per-period led high counts 0,4,8,8,4,0,0, then done pulse aligned with busy falling and duty=0 thereafter.
- Same config, repeat=0; stop asserted during the 2nd period at duty 8 -> next periods 4,0,0, then done; no further breaths.
- min=10, max=5, start -> err pulse one cycle, busy stays 0, led stays 0.
- min=0, max=250, step=100, hold=0, repeat=2 -> duty 0,100,200,250,150,50,0,100,200,250,150,50,0, then done; saturation at 250 and 0 checked.
- cfg changed mid-run (max 8 -> 200) plus start pulses while busy -> profile unchanged from the captured config; no restart.
- rst asserted mid-HOLD_HI -> the next cycle shows led=0, duty=0, busy=0, state IDLE; a subsequent start runs normally from LOAD.
